// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared AHB-Lite codes, memory map and master script steps
package soc_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [31:0] DEF_REG_BASE    = 32'h4000_0000;
   localparam int          DEF_NUM_REGS    = 3;
   localparam logic [31:0] REG_REGION_SIZE = 32'(4 * DEF_NUM_REGS);

   typedef enum logic [2:0] {W_R0, W_R1, R_R0, R_R1, W_SUM, DONE} step_t;

endpackage

// File: rtl/ahb_reg_slave.sv
// rtl/ahb_reg_slave.sv - zero-wait AHB-Lite register file with flat register export
module ahb_reg_slave import soc_pkg::*; #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hsel,
   input  logic [1:0]                 htrans,
   input  logic [2:0]                 hsize,
   input  logic                       hwrite,
   input  logic [1:0]                 haddr_idx,
   input  logic                       hready,
   input  logic [DATA_W-1:0]          hwdata,
   output logic [DATA_W-1:0]          hrdata,
   output logic                       hreadyout,
   output logic                       hresp,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              wr_pend;
   logic [1:0]        idx_q;
   logic              idx_ok;
   logic              xfer;

   assign xfer   = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hsize == HSIZE_WORD;
   assign idx_ok = ({30'b0, idx_q} < 32'(NUM_REGS));

   // Address phase is latched; the write lands on the edge that closes the data phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pend <= 1'b0;
         idx_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else begin
         if (wr_pend && hready && idx_ok) mem[idx_q] <= hwdata;
         if (hready) begin
            wr_pend <= xfer && hwrite;
            idx_q   <= haddr_idx;
         end
      end
   end

   assign hrdata    = idx_ok ? mem[idx_q] : '0;
   assign hreadyout = 1'b1;
   assign hresp     = HRESP_OKAY;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[(NUM_REGS-1-g)*DATA_W +: DATA_W] = mem[g];
   end

endmodule

// File: rtl/ahb_lite_soc.sv
// rtl/ahb_lite_soc.sv - script-driven AHB-Lite master, decoder, register and default slaves
module ahb_lite_soc import soc_pkg::*; #(
   parameter int                DATA_W   = 32,
   parameter int                NUM_REGS = 3,
   parameter logic [31:0]       REG_BASE = DEF_REG_BASE,
   parameter logic [DATA_W-1:0] OPA      = 32'h0000_0005,
   parameter logic [DATA_W-1:0] OPB      = 32'h0000_0007
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   output logic [NUM_REGS*DATA_W-1:0] registers
);

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

   step_t             step, step_nxt;
   logic              data_ph, data_ph_nxt;
   logic [DATA_W-1:0] opa_q, opb_q, opa_nxt, opb_nxt;
   logic [31:0]       haddr;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic              hwrite;
   logic [DATA_W-1:0] hwdata, hrdata, reg_hrdata;
   logic              hready, hresp, reg_hreadyout, reg_hresp;
   logic              sel_reg, dsel_reg, def_start;
   ds_t               ds, ds_nxt;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         step     <= W_R0;
         data_ph  <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         dsel_reg <= 1'b0;
         ds       <= DS_IDLE;
      end else begin
         step    <= step_nxt;
         data_ph <= data_ph_nxt;
         opa_q   <= opa_nxt;
         opb_q   <= opb_nxt;
         ds      <= ds_nxt;
         if (hready) dsel_reg <= sel_reg;
      end
   end

   // Script addresses are fixed to the shipped map; the decoder follows REG_BASE.
   always_comb begin
      step_nxt    = step;
      data_ph_nxt = data_ph;
      opa_nxt     = opa_q;
      opb_nxt     = opb_q;
      htrans      = HTRANS_IDLE;
      hsize       = HSIZE_WORD;
      hwrite      = 1'b0;
      haddr       = DEF_REG_BASE;
      hwdata      = '0;
      case (step)
         W_R0:  begin hwrite = 1'b1; hwdata = OPA; end
         W_R1:  begin hwrite = 1'b1; hwdata = OPB; haddr = DEF_REG_BASE + 32'd4; end
         R_R1:  haddr = DEF_REG_BASE + 32'd4;
         W_SUM: begin hwrite = 1'b1; hwdata = opa_q + opb_q; haddr = DEF_REG_BASE + 32'd8; end
         default: ;
      endcase
      if (step != DONE) begin
         if (!data_ph) begin
            if (!HRESET) htrans = HTRANS_NONSEQ;
            if (hready) data_ph_nxt = 1'b1;
         end else if (hready) begin
            data_ph_nxt = 1'b0;
            if (hresp == HRESP_ERROR) begin
               step_nxt = DONE;
            end else begin
               if (step == R_R0) opa_nxt = hrdata;
               if (step == R_R1) opb_nxt = hrdata;
               step_nxt = step_t'(step + 3'd1);
            end
         end
      end
   end

   assign sel_reg   = (haddr >= REG_BASE) && (haddr < REG_BASE + 32'(4 * NUM_REGS));
   assign def_start = !sel_reg && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

   always_comb begin
      ds_nxt = ds;
      case (ds)
         DS_ERR1: ds_nxt = DS_ERR2;
         default: ds_nxt = def_start ? DS_ERR1 : DS_IDLE;
      endcase
   end

   // Response mux follows the slave owning the current data phase.
   assign hready = dsel_reg ? reg_hreadyout : (ds != DS_ERR1);
   assign hresp  = dsel_reg ? reg_hresp : ((ds != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY);
   assign hrdata = dsel_reg ? reg_hrdata : '0;

   ahb_reg_slave #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regs (
      .clk       (HCLK),
      .rst       (HRESET),
      .hsel      (sel_reg),
      .htrans    (htrans),
      .hsize     (hsize),
      .hwrite    (hwrite),
      .haddr_idx (haddr[3:2]),
      .hready    (hready),
      .hwdata    (hwdata),
      .hrdata    (reg_hrdata),
      .hreadyout (reg_hreadyout),
      .hresp     (reg_hresp),
      .regs_flat (registers)
   );

endmodule

// File: tb/tb_ahb_lite_soc.sv
// tb/tb_ahb_lite_soc.sv - self-checking bench for ahb_lite_soc
module tb_ahb_lite_soc;
   import soc_pkg::*;

   logic        HCLK   = 1'b0;
   logic        HRESET = 1'b1;
   logic [95:0] regs_main, regs_wrap, regs_err;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int          cyc;
      logic [95:0] exp;
   } vec_t;
   vec_t tbl[7];

   always #5 HCLK = ~HCLK;

   ahb_lite_soc dut (.HCLK(HCLK), .HRESET(HRESET), .registers(regs_main));
   ahb_lite_soc #(.OPA(32'hFFFF_FFFF), .OPB(32'h0000_0002)) dut_wrap (
      .HCLK(HCLK), .HRESET(HRESET), .registers(regs_wrap));
   ahb_lite_soc #(.REG_BASE(32'h5000_0000)) dut_err (
      .HCLK(HCLK), .HRESET(HRESET), .registers(regs_err));

   // k = rising edges sampled with reset low since the last release
   function automatic logic [95:0] model(int k, logic [31:0] a, logic [31:0] b);
      logic [31:0] r0, r1, r2;
      r0 = (k >= 2)  ? a : 32'h0;
      r1 = (k >= 4)  ? b : 32'h0;
      r2 = (k >= 10) ? a + b : 32'h0;
      return {r0, r1, r2};
   endfunction

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check96(string name, logic [95:0] act, logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic checkv(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_table(string tag);
      int k = 0;
      foreach (tbl[i]) begin
         while (k < tbl[i].cyc) begin
            tick();
            k++;
         end
         check96($sformatf("%s_cyc%0d", tag, tbl[i].cyc), regs_main, tbl[i].exp);
      end
   endtask

   task automatic mon(string name, logic [1:0] htrans, logic [2:0] hsize, logic hready);
      checks++;
      if (!(htrans inside {HTRANS_IDLE, HTRANS_NONSEQ}) || hsize != HSIZE_WORD ||
          (!hready && htrans != HTRANS_IDLE)) begin
         errors++;
         $display("FAIL %s htrans=%b hsize=%b hready=%b", name, htrans, hsize, hready);
      end
   endtask

   always @(negedge HCLK) begin
      if (!HRESET) begin
         mon("mon_main", dut.htrans, dut.hsize, dut.hready);
         mon("mon_err", dut_err.htrans, dut_err.hsize, dut_err.hready);
      end
   end

   initial begin
      tbl[0] = '{1,  96'h0};
      tbl[1] = '{2,  {32'h5, 32'h0, 32'h0}};
      tbl[2] = '{3,  {32'h5, 32'h0, 32'h0}};
      tbl[3] = '{4,  {32'h5, 32'h7, 32'h0}};
      tbl[4] = '{9,  {32'h5, 32'h7, 32'h0}};
      tbl[5] = '{10, {32'h5, 32'h7, 32'hC}};
      tbl[6] = '{12, {32'h5, 32'h7, 32'hC}};

      HRESET = 1'b1;
      repeat (5) begin
         tick();
         check96("reset_main", regs_main, 96'h0);
         check96("reset_wrap", regs_wrap, 96'h0);
         check96("reset_err", regs_err, 96'h0);
      end
      HRESET = 1'b0;

      for (int k = 1; k <= 12; k++) begin
         tick();
         foreach (tbl[i]) if (tbl[i].cyc == k)
            check96($sformatf("first_cyc%0d", k), regs_main, tbl[i].exp);
         check96($sformatf("wrap_cyc%0d", k), regs_wrap, model(k, 32'hFFFF_FFFF, 32'h2));
         check96($sformatf("err_regs_cyc%0d", k), regs_err, 96'h0);
         if (k == 1) begin
            checkv("err_wait_hready", int'(dut_err.hready), 0);
            checkv("err_wait_hresp", int'(dut_err.hresp), int'(HRESP_ERROR));
         end
         if (k == 2) begin
            checkv("err_last_hready", int'(dut_err.hready), 1);
            checkv("err_last_hresp", int'(dut_err.hresp), int'(HRESP_ERROR));
         end
         if (k == 3) checkv("err_step_done", int'(dut_err.step), int'(DONE));
      end

      for (int n = 0; n < 100; n++) begin
         tick();
         check96("steady_main", regs_main, {32'h5, 32'h7, 32'hC});
         check96("steady_wrap", regs_wrap, {32'hFFFF_FFFF, 32'h2, 32'h1});
         check96("steady_err", regs_err, 96'h0);
      end
      checkv("err_step_final", int'(dut_err.step), int'(DONE));

      HRESET = 1'b1;
      tick();
      check96("pre_mid_reset", regs_main, 96'h0);
      HRESET = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check96($sformatf("mid_run_cyc%0d", k), regs_main, model(k, 32'h5, 32'h7));
      end
      HRESET = 1'b1;
      repeat (2) begin
         tick();
         check96("mid_reset", regs_main, 96'h0);
      end
      HRESET = 1'b0;
      run_table("rebuild");

      HRESET = 1'b1;
      tick();
      check96("pre_rand_reset", regs_main, 96'h0);
      HRESET = 1'b0;
      for (int it = 0; it < 8; it++) begin
         int r   = int'($urandom_range(1, 14));
         int len = int'($urandom_range(1, 3));
         for (int k = 1; k <= r; k++) begin
            tick();
            check96($sformatf("rand%0d_cyc%0d", it, k), regs_main, model(k, 32'h5, 32'h7));
         end
         HRESET = 1'b1;
         repeat (len) begin
            tick();
            check96($sformatf("rand%0d_reset", it), regs_main, 96'h0);
         end
         HRESET = 1'b0;
      end
      for (int k = 1; k <= 12; k++) begin
         tick();
         check96($sformatf("final_cyc%0d", k), regs_main, model(k, 32'h5, 32'h7));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_lite_soc.md
Name: ahb_lite_soc

Overview:
Minimal AHB-Lite SoC top for the tinyml platform. Contains one script-driven AHB-Lite master, an address decoder, a 3-word register-file slave and a default (error) slave. After reset the master runs a fixed bus script that loads two operands, reads them back and writes their sum. The three slave registers are exported flat for observation.

Parameters:
DATA_W, 32, AHB data and register width
NUM_REGS, 3, number of register-file words
REG_BASE, 32'h4000_0000, base address of the register file (word stride 4)
OPA, 32'h0000_0005, operand written to R0
OPB, 32'h0000_0007, operand written to R1

Ports:
HCLK  input  1  system clock; all state on its rising edge
HRESET  input  1  synchronous, active-high reset
registers  output  NUM_REGS*DATA_W (96)  {R0,R1,R2}; R0 in bits [95:64], R1 in [63:32], R2 in [31:0]

Behaviour:
- Reset: while HRESET is high at a rising edge, R0/R1/R2 go to 0 (registers=96'h0). Master returns to script step 0 with HTRANS=IDLE. Captured read data is cleared. Reset mid-script aborts the script and restarts it cleanly.
- Bus: AHB-Lite with HSIZE=word, HBURST=SINGLE and HPROT fixed.
  - The master is non-pipelined. Address phase has HTRANS=NONSEQ. The data phase follows with HTRANS=IDLE. Each transfer takes 2 cycles when HREADY=1.
- Decoder: address in [REG_BASE, REG_BASE+4*NUM_REGS) selects the register slave, index = HADDR[3:2]. All other addresses select the default slave.
- Register slave:
  - Zero wait state: HREADYOUT=1, HRESP=OKAY.
  - Write data is taken in the data phase. The register updates at the rising edge that ends the data phase.
  - Reads return the register value in the data phase.
- Default slave: standard 2-cycle ERROR response (HREADYOUT=0 then 1, HRESP=ERROR both cycles). IDLE transfers get OKAY.
- Master script (steps counted from first edge with HRESET low = cycle 1):
  - 1. write R0=OPA (cycles 1-2)
  - 2. write R1=OPB (3-4)
  - 3. read R0 into opa_q (5-6)
  - 4. read R1 into opb_q (7-8)
  - 5. write R2=opa_q+opb_q, modulo 2^32, carry discarded (9-10)
  - 6. DONE: HTRANS=IDLE forever until reset.
- Register visibility: R0 visible on registers after the edge ending cycle 2, R1 after cycle 4, R2 after cycle 10.
- Error during script: on HRESP=ERROR the master drops to DONE with no further writes. The shipped script cannot error; this path is reached only by changing REG_BASE or the script.
- HREADY low: the master holds its address/data phase until HREADY=1.
- HRDATA mux is selected by the slave latched in the address phase, not the current HADDR.

Decomposition:
- Package soc_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HSIZE_WORD, HRESP codes
  - REG_BASE and region size
  - script step enum: W_R0, W_R1, R_R0, R_R1, W_SUM, DONE
- Natural sub-module: ahb_reg_slave (NUM_REGS words, AHB-Lite slave port, flat register output).
- Master FSM, decoder/mux and default slave stay in the top.

Test Plan:
- Assert HRESET for 5 cycles, then release -> registers=96'h0 during reset. After 10 cycles, registers = {32'h5, 32'h7, 32'hC} and stays constant for 100 further cycles.
- Cycle-check after release -> R0=5 visible after cycle 2, R1=7 after cycle 4, R2 still 0 until the edge ending cycle 10.
- Assert HRESET at cycle 6 (mid read of R0) for 2 cycles, then release -> registers=0 immediately, then the same {5,7,C} sequence rebuilt with identical timing.
- Override OPA=32'hFFFF_FFFF, OPB=32'h2 -> R2=32'h1 (wrap, carry dropped).
- Override REG_BASE so script address misses -> default slave 2-cycle ERROR, master enters DONE, registers remain 0.
- Bus protocol monitor throughout: HTRANS only IDLE/NONSEQ, HSIZE=word, no new address phase while HREADY=0.
